// File: rtl/float_to_posit_if.sv
// rtl/float_to_posit_if.sv - operand/result bundle for the float-to-posit encoder
//
// Purpose: groups the operand, start strobe and encoded result/flags.
// Signals:
//   in     [31:0]  IEEE-754 binary32 operand
//   start          in is valid this cycle
//   result [N-1:0] posit encoding
//   inf            operand was Inf/NaN, result is NaR
//   zero           operand was zero/subnormal, result is 0
//   done           result/inf/zero valid this cycle
// master: host side (drives in/start); slave: encoder side.
interface float_to_posit_if #(
    parameter int N = 32
);
    logic [31:0]  in;
    logic         start;
    logic [N-1:0] result;
    logic         inf;
    logic         zero;
    logic         done;

    modport master (output in, start, input result, inf, zero, done);
    modport slave  (input in, start, output result, inf, zero, done);
endinterface

// File: rtl/float_to_posit.sv
// rtl/float_to_posit.sv - pipelined IEEE-754 binary32 to posit<N,es> encoder
//
// Purpose: converts one binary32 operand per cycle into posit<N,es>.
//   An operand sampled with start=1 at edge t is presented with done=1
//   after edge t+3. No stall, no backpressure; outputs hold while done=0.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, clears every valid bit
//   bus   float_to_posit_if.slave (in/start in, result/inf/zero/done out);
//         the interface instance must be built with the same N.
module float_to_posit #(
    parameter int N  = 32,
    parameter int es = 2,
    parameter int Bs = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    float_to_posit_if.slave bus
);
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2
    } cls_e;

    localparam logic signed [8:0] K_HI   = 9'(N - 2);
    localparam logic signed [8:0] K_LO   = 9'(1 - N);
    localparam logic [2*N-1:0]    ONE_2N = {{(2*N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]      ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-2:0]      MAXPOS = {(N-1){1'b1}};
    localparam logic [N-2:0]      MINPOS = {{(N-2){1'b0}}, 1'b1};

    // ---------------- S0: capture and classify ----------------
    logic        s0_vld_q;
    logic        s0_sign_q;
    logic [7:0]  s0_exp_q;
    logic [22:0] s0_man_q;
    cls_e        s0_cls_q, s0_cls_d;

    always_comb begin
        s0_cls_d = CLS_NORM;
        if (bus.in[30:23] == 8'hFF)      s0_cls_d = CLS_INF;
        else if (bus.in[30:23] == 8'h00) s0_cls_d = CLS_ZERO;
    end

    // ---------------- S1: scale decomposition ----------------
    logic signed [8:0] scale, k;
    logic [25:0]       em_full;
    logic [25:0]       em_d;
    logic [Bs-1:0]     amt_d;

    logic          s1_vld_q, s1_sign_q, s1_neg_q, s1_sat_hi_q, s1_sat_lo_q;
    cls_e          s1_cls_q;
    logic [Bs-1:0] s1_amt_q;
    logic [25:0]   s1_em_q;

    always_comb begin
        scale   = $signed({1'b0, s0_exp_q}) - 9'sd127;
        k       = scale >>> es;
        // Left-justify {e, M}: the constant shift drops the scale bits above e.
        em_full = {scale[2:0], s0_man_q};
        em_d    = em_full << (3 - es);
        // Arithmetic shift of {~neg, neg, ...} replicates the MSB: k>=0 needs
        // k extra ones before the terminating 0, k<0 needs -k-1 extra zeros
        // before the terminating 1 (-k-1 == ~k).
        amt_d   = k[8] ? ~k[Bs-1:0] : k[Bs-1:0];
    end

    // ---------------- S2: regime placement ----------------
    logic [2*N-1:0] vec, shifted, lost_mask;
    logic           lost;
    logic           s2_vld_q, s2_sign_q, s2_sat_hi_q, s2_sat_lo_q;
    cls_e           s2_cls_q;
    logic [N-2:0]   s2_body_q;
    logic           s2_guard_q, s2_sticky_q;

    always_comb begin
        vec       = {~s1_neg_q, s1_neg_q, s1_em_q, {(2*N-28){1'b0}}};
        shifted   = $signed(vec) >>> s1_amt_q;
        // Mantissa bits pushed off the bottom still feed sticky.
        lost_mask = (ONE_2N << s1_amt_q) - ONE_2N;
        lost      = |(vec & lost_mask);
    end

    // ---------------- Output: round, saturate, sign ----------------
    logic         inc;
    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic [N-1:0] signed_res, result_d;

    always_comb begin
        inc = s2_guard_q & (s2_sticky_q | s2_body_q[0]);
        sum = {1'b0, s2_body_q} + {{(N-1){1'b0}}, inc};
        if (s2_sat_hi_q || sum[N-1])                  mag = MAXPOS;
        else if (s2_sat_lo_q || sum[N-2:0] == '0)     mag = MINPOS;
        else                                          mag = sum[N-2:0];
        signed_res = s2_sign_q ? (~{1'b0, mag} + ONE_N) : {1'b0, mag};
        result_d   = signed_res;
        if (s2_cls_q == CLS_INF)       result_d = {1'b1, {(N-1){1'b0}}};
        else if (s2_cls_q == CLS_ZERO) result_d = '0;
    end

    logic [N-1:0] result_q;
    logic         inf_q, zero_q, done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld_q <= 1'b0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            s0_vld_q <= bus.start;
            s1_vld_q <= s0_vld_q;
            s2_vld_q <= s1_vld_q;
            done_q   <= s2_vld_q;
            if (s2_vld_q) begin
                result_q <= result_d;
                inf_q    <= (s2_cls_q == CLS_INF);
                zero_q   <= (s2_cls_q == CLS_ZERO);
            end
        end

        s0_sign_q   <= bus.in[31];
        s0_exp_q    <= bus.in[30:23];
        s0_man_q    <= bus.in[22:0];
        s0_cls_q    <= s0_cls_d;

        s1_sign_q   <= s0_sign_q;
        s1_cls_q    <= s0_cls_q;
        s1_neg_q    <= k[8];
        s1_amt_q    <= amt_d;
        s1_sat_hi_q <= (k >= K_HI);
        s1_sat_lo_q <= (k <= K_LO);
        s1_em_q     <= em_d;

        s2_sign_q   <= s1_sign_q;
        s2_cls_q    <= s1_cls_q;
        s2_sat_hi_q <= s1_sat_hi_q;
        s2_sat_lo_q <= s1_sat_lo_q;
        s2_body_q   <= shifted[2*N-1:N+1];
        s2_guard_q  <= shifted[N];
        s2_sticky_q <= (|shifted[N-1:0]) | lost;
    end

    assign bus.result = result_q;
    assign bus.inf    = inf_q;
    assign bus.zero   = zero_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_float_to_posit.sv
// tb/tb_float_to_posit.sv - scoreboard bench for the float-to-posit encoder
module tb_float_to_posit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    float_to_posit_if #(.N(32)) bus();

    float_to_posit #(.N(32), .es(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        inf;
        logic        zero;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic [31:0] last_res  = '0;
    logic        last_inf  = 1'b0;
    logic        last_zero = 1'b0;

    localparam int NV = 20;
    logic [31:0] tv_in [NV] = '{
        32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000, 32'h7F800000,
        32'h7FC00000, 32'h00000000, 32'h80000000, 32'h00000001, 32'h3F800001,
        32'h5F801001, 32'h5F801800, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00800000,
        32'h40400000, 32'h3E800000, 32'h37800000, 32'hFF800000, 32'h807FFFFF};
    logic [31:0] tv_res [NV] = '{
        32'h40000000, 32'h48000000, 32'h38000000, 32'hC0000000, 32'h80000000,
        32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h40000010,
        32'h7FFFC001, 32'h7FFFC002, 32'h7FFFFFFF, 32'h80000001, 32'h00000001,
        32'h4C000000, 32'h30000000, 32'h04000000, 32'h80000000, 32'h00000000};
    logic tv_inf  [NV] = '{0,0,0,0,1, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,1,0};
    logic tv_zero [NV] = '{0,0,0,0,0, 0,1,1,1,0, 0,0,0,0,0, 0,0,0,0,1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_out(input logic r);
        exp_t e;
        if (r) begin
            chk("rst_done", {31'b0, bus.done}, 32'd0);
            chk("rst_result", bus.result, 32'd0);
            chk("rst_inf", {31'b0, bus.inf}, 32'd0);
            chk("rst_zero", {31'b0, bus.zero}, 32'd0);
            last_res = '0; last_inf = 1'b0; last_zero = 1'b0;
        end else if (bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'b0, bus.done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc, e.due);
                chk("result", bus.result, e.res);
                chk("inf", {31'b0, bus.inf}, {31'b0, e.inf});
                chk("zero", {31'b0, bus.zero}, {31'b0, e.zero});
            end
            last_res = bus.result; last_inf = bus.inf; last_zero = bus.zero;
        end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("done_missing", {31'b0, bus.done}, 32'd1);
                void'(sb.pop_front());
            end
            chk("hold_result", bus.result, last_res);
            chk("hold_flags", {30'b0, bus.inf, bus.zero}, {30'b0, last_inf, last_zero});
        end
    endtask

    task automatic step(input logic st, input int idx, input logic r);
        exp_t e;
        bus.start = st;
        bus.in    = st ? tv_in[idx] : 32'h0;
        rst       = r;
        if (r) begin
            sb.delete();
        end else if (st) begin
            e.res = tv_res[idx]; e.inf = tv_inf[idx]; e.zero = tv_zero[idx];
            e.due = cyc + 4;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        check_out(r);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.in    = '0;
        rst       = 1'b1;

        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            step(1, i, 0);
            repeat (4) step(0, 0, 0);
        end

        for (int i = 0; i < 5; i++) step(1, i, 0);
        repeat (5) step(0, 0, 0);

        for (int i = 0; i < NV; i++) step(1, i, 0);
        repeat (6) step(0, 0, 0);

        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 2, 1);
        repeat (6) step(0, 0, 0);
        step(1, 3, 0);
        repeat (4) step(0, 0, 0);

        for (int g = 0; g < 20 && sb.size() > 0; g++) step(0, 0, 0);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
